// File: rtl/seq_mag_comp.sv
// seq_mag_comp: multi-cycle magnitude comparator.
//
// Latches two WIDTH-bit operands on a start request. It then compares them
// MSB-first, CHUNK bits per cycle. It stops at the first chunk that differs,
// or after the last chunk if all chunks are equal.
// Signed operands are first mapped to offset-binary by flipping the MSB.
// After that mapping, an unsigned compare gives the two's-complement ordering.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        compare request, accepted only while idle
//   signed_mode  1 = two's-complement compare, 0 = unsigned (sampled with start)
//   a, b         operands (sampled with start)
//   busy         high while a compare is in progress
//   done         one-cycle pulse: result outputs have just been updated
//   a_eq_b       A == B  (held until the next done)
//   a_gt_b       A >  B  (held until the next done)
//   a_lt_b       A <  B  (held until the next done)
module seq_mag_comp #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b
);

    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCH        = WIDTH / CHUNK_SAFE;
    localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if (CHUNK < 1) begin : g_chk_chunk
        $error("seq_mag_comp: CHUNK must be at least 1");
    end else if ((WIDTH % CHUNK) != 0) begin : g_chk_width
        $error("seq_mag_comp: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            eq_q, eq_d;
    logic            gt_q, gt_d;
    logic            lt_q, lt_d;

    // Operand shift registers. The chunk under test is always the top CHUNK bits.
    logic [WIDTH-1:0] a_q, b_q;
    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic             accept;
    logic             chunk_diff;
    logic             last_chunk;
    logic             finish;

    assign chunk_a    = a_q[WIDTH-1 -: CHUNK];
    assign chunk_b    = b_q[WIDTH-1 -: CHUNK];
    assign accept     = (state_q == IDLE) && start;
    assign chunk_diff = (chunk_a != chunk_b);
    assign last_chunk = (cnt_q == CW'(NCH - 1));
    assign finish     = (state_q == CMP) && (chunk_diff || last_chunk);

    // Datapath registers carry no reset. They are only read in CMP,
    // and CMP is always entered through a load.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a ^ (signed_mode ? MSB_MASK : '0);
            b_q <= b ^ (signed_mode ? MSB_MASK : '0);
        end else if (state_q == CMP) begin
            a_q <= a_q << CHUNK;
            b_q <= b_q << CHUNK;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start)  state_d = CMP;
            CMP:  if (finish) state_d = IDLE;
            default:          state_d = IDLE;
        endcase
    end

    // Output and counter next values
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = (state_d == CMP);
        done_d = finish;
        eq_d   = eq_q;
        gt_d   = gt_q;
        lt_d   = lt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == CMP) begin
            cnt_d = cnt_q + CW'(1);
        end
        // A finish with no differing chunk can only come from the last chunk, so it means equal.
        if (finish) begin
            eq_d = !chunk_diff;
            gt_d = chunk_diff && (chunk_a > chunk_b);
            lt_d = chunk_diff && (chunk_a < chunk_b);
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign a_eq_b = eq_q;
    assign a_gt_b = gt_q;
    assign a_lt_b = lt_q;

endmodule

// File: tb/tb_seq_mag_comp.sv
module tb_seq_mag_comp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, eq16, gt16, lt16;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, eq8, gt8, lt8;

    seq_mag_comp #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .busy(busy16), .done(done16),
        .a_eq_b(eq16), .a_gt_b(gt16), .a_lt_b(lt16)
    );

    seq_mag_comp #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .a_eq_b(eq8), .a_gt_b(gt8), .a_lt_b(lt8)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far; stable when sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int   cyc;
        logic eq;
        logic gt;
        logic lt;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor for the 16-bit instance
    logic prev16 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done16) begin
            chk("done16_single_pulse", int'(prev16), 0);
            chk("busy16_low_at_done", int'(busy16), 0);
            if (q16.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL done16_unexpected: done seen at edge %0d with nothing pending", cyc);
            end else begin
                e = q16.pop_front();
                chk("done16_edge", cyc, e.cyc);
                chk("result16_eq_gt_lt", int'({eq16, gt16, lt16}), int'({e.eq, e.gt, e.lt}));
            end
        end
        prev16 <= done16;
    end

    // Monitor for the 8-bit, single-chunk instance
    logic prev8 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (done8) begin
            chk("done8_single_pulse", int'(prev8), 0);
            if (q8.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL done8_unexpected: done seen at edge %0d with nothing pending", cyc);
            end else begin
                e = q8.pop_front();
                chk("done8_edge", cyc, e.cyc);
                chk("result8_eq_gt_lt", int'({eq8, gt8, lt8}), int'({e.eq, e.gt, e.lt}));
            end
        end
        prev8 <= done8;
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (q16.size() == 0 && q8.size() == 0 && !busy16 && !busy8) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: pending16=%0d pending8=%0d required=0", q16.size(), q8.size());
        end
        @(negedge clk);
    endtask

    // Issue one compare; k is the hand-computed edge offset of done.
    task automatic issue(input bit w8, input logic [15:0] av, input logic [15:0] bv,
                         input logic sm, input int k,
                         input logic e_eq, input logic e_gt, input logic e_lt);
        int t;
        @(negedge clk);
        t = cyc + 1;
        if (w8) begin
            a8 = av[7:0]; b8 = bv[7:0]; sm8 = sm; start8 = 1'b1;
            q8.push_back('{t + k, e_eq, e_gt, e_lt});
        end else begin
            a16 = av; b16 = bv; sm16 = sm; start16 = 1'b1;
            q16.push_back('{t + k, e_eq, e_gt, e_lt});
        end
        @(negedge clk);
        start8  = 1'b0;
        start16 = 1'b0;
        if (w8) chk("busy8_after_accept", int'(busy8 | done8), 1);
        else    chk("busy16_after_accept", int'(busy16), 1);
        wait_idle();
    endtask

    initial begin
        int t;
        #2;
        chk("reset16_outputs", int'({busy16, done16, eq16, gt16, lt16}), 0);
        chk("reset8_outputs", int'({busy8, done8, eq8, gt8, lt8}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Equal, unsigned: full NCH cycles
        issue(0, 16'h0000, 16'h0000, 0, 4, 1, 0, 0);
        // Differ only in last chunk
        issue(0, 16'h1234, 16'h1235, 0, 4, 0, 0, 1);
        issue(0, 16'h1235, 16'h1234, 0, 4, 0, 1, 0);
        // First chunk decides; signed reverses the order
        issue(0, 16'hA000, 16'h1FFF, 0, 1, 0, 1, 0);
        issue(0, 16'hA000, 16'h1FFF, 1, 1, 0, 0, 1);
        // Middle chunks decide
        issue(0, 16'h1200, 16'h1300, 0, 2, 0, 0, 1);
        issue(0, 16'h12F0, 16'h12E0, 0, 3, 0, 1, 0);
        // Signed extremes
        issue(0, 16'h8000, 16'h7FFF, 1, 1, 0, 0, 1);
        issue(0, 16'hFFFF, 16'h0001, 1, 1, 0, 0, 1);
        issue(0, 16'hFFFE, 16'hFFFF, 1, 4, 0, 0, 1);
        issue(0, 16'hFFFF, 16'h0001, 0, 1, 0, 1, 0);

        // Start held through busy with operands changed in flight, then back-to-back accept
        @(negedge clk);
        t = cyc + 1;
        a16 = 16'h00F0; b16 = 16'h00F1; sm16 = 1'b0; start16 = 1'b1;
        q16.push_back('{t + 4, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0000;
        q16.push_back('{t + 6, 1'b0, 1'b1, 1'b0});
        while (cyc < t + 5) @(negedge clk);
        start16 = 1'b0;
        wait_idle();

        // Asynchronous reset mid-compare: everything clears, no done
        @(negedge clk);
        a16 = 16'hFFF0; b16 = 16'hFFF1; sm16 = 1'b0; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midop_reset16_outputs", int'({busy16, done16, eq16, gt16, lt16}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(0, 16'h5555, 16'h5555, 0, 4, 1, 0, 0);

        // Single-chunk instance: always one cycle
        issue(1, 16'h0080, 16'h007F, 1, 1, 0, 0, 1);
        issue(1, 16'h0080, 16'h007F, 0, 1, 0, 1, 0);
        issue(1, 16'h007F, 16'h007F, 1, 1, 1, 0, 0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
Parametrised, multi-cycle magnitude comparator. It is the successor to the team's fixed 4-bit equality comparator. The block latches two WIDTH-bit operands on a start handshake and compares them MSB-first, CHUNK bits per cycle, terminating early on the first differing chunk. It reports equal, greater-than and less-than in unsigned or two's-complement mode. It is intended for datapaths where a wide single-cycle comparator would break timing.

Parameters:
WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK
CHUNK, 4, bits compared per cycle; NCH = WIDTH/CHUNK chunks
(derived) CW, max(1, clog2(NCH)), chunk-index counter width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while a compare is in progress
done  output  1  single-cycle pulse; result outputs are valid/updated
a_eq_b  output  1  A == B
a_gt_b  output  1  A > B
a_lt_b  output  1  A < B

Behaviour:
- Clocking and reset: one clock domain; reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: state = IDLE, busy = 0, done = 0, a_eq_b = a_gt_b = a_lt_b = 0, chunk counter = 0.
- States:
  - IDLE: start = 1 at edge T latches a, b and signed_mode, clears the counter, sets busy = 1 and moves to CMP.
  - CMP: at each edge T+k (k = 1..NCH) compares latched chunk k-1, counted from MSB.
- Signed mode: at latch, the MSB of both operands is inverted (offset-binary). The compare is then unsigned throughout.
- Early termination: if chunk k-1 differs at edge T+k:
  - set a_gt_b or a_lt_b per the chunk compare; clear the other two results;
  - done = 1, busy = 0, state → IDLE.
- All-equal: if the counter reaches the last chunk (NCH-1) and it is equal, at edge T+NCH set a_eq_b = 1, clear gt/lt, done = 1, busy = 0, state → IDLE.
- Latency: done rises at edge T+k, where k is the first differing chunk (1..NCH). Worst case is NCH cycles; the minimum is 1 cycle.
- done pulse: high for exactly one cycle and deasserts at the next edge.
- Result hold: results hold their value until the next done. After any done, exactly one of eq/gt/lt is 1. Results do not change at start acceptance.
- start handling:
  - start while busy (CMP) is ignored; it is neither queued nor a restart.
  - Earliest next accept is edge T+k+1, i.e. start high in the cycle where done is high. Back-to-back throughput is therefore k+1 cycles per compare.
- Operand changes: changes to a, b or signed_mode while busy do not affect the result in flight.
- Reset mid-operation: rst_n low asynchronously forces the reset values and no done is produced. After release, the first start is accepted normally.
- NCH = 1: CMP lasts one cycle and done always rises at T+1.
- Parameter check: elaboration fails if WIDTH % CHUNK ≠ 0 or CHUNK < 1.

Test Plan:
1. WIDTH=16, CHUNK=4; a=0x0000, b=0x0000, unsigned; start at edge T → busy high T..T+4, done pulse at T+4, a_eq_b=1, gt=lt=0.
2. a=0x1234, b=0x1235, unsigned → done at T+4, a_lt_b=1. Then a=0x1235, b=0x1234 → done at T+4, a_gt_b=1.
3. a=0xA000, b=0x1FFF: unsigned → done at T+1, a_gt_b=1. Repeat with signed_mode=1 → done at T+1, a_lt_b=1 (−24576 < 8191).
4. Start a=0x00F0, b=0x00F1; pulse start again at T+1 and change a/b to 0xFFFF/0x0000 during busy → single done at T+4, a_lt_b=1, no second compare. Start held high continuously → next accept exactly one cycle after done.
5. Start a compare, drive rst_n low at T+2 → busy, done and results 0 immediately, no done. Release, then start a=b=0x5555 → done at T+4, a_eq_b=1.
6. WIDTH=8, CHUNK=8; signed_mode=1, a=0x80, b=0x7F → done at T+1, a_lt_b=1. Unsigned, same operands → a_gt_b=1.
